// File: rtl/seq_divider_12.sv
// Iterative restoring divider: one subtract-and-shift step per clock, results registered on leaving DONE.
// Optional feature: define SIGNED_DIV_EN for two's-complement operands (adds the SFIX sign-fix state).
module seq_divider_12 #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             dbz
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef SIGNED_DIV_EN
  localparam logic [1:0] S_SFIX = 2'd3;
`endif

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  // R is only ever loaded with a non-negative T, so its top bit is always zero and not stored.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    count;
  logic             zero_div;
  logic [WIDTH:0]   s_val;
  logic [WIDTH:0]   t_val;
  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;
  assign op_dividend = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign op_divisor  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
  assign op_dividend = dividend;
  assign op_divisor  = divisor;
`endif

  assign s_val = {r_reg, q_reg[WIDTH-1]};
  assign t_val = s_val - {1'b0, d_reg};
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      d_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
      zero_div  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ready     <= 1'b0;
      dbz       <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= '0;
            r_reg <= '0;
            d_reg <= op_divisor;
`ifdef SIGNED_DIV_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              // Keep the raw dividend: it becomes the remainder of a divide-by-zero.
              zero_div <= 1'b1;
              q_reg    <= dividend;
              state    <= S_DONE;
            end else begin
              zero_div <= 1'b0;
              q_reg    <= op_dividend;
              state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!t_val[WIDTH]) begin
            r_reg <= t_val[WIDTH-1:0];
            q_reg <= {q_reg[WIDTH-2:0], 1'b1};
          end else begin
            r_reg <= s_val[WIDTH-1:0];
            q_reg <= {q_reg[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == LAST) begin
`ifdef SIGNED_DIV_EN
            state <= S_SFIX;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef SIGNED_DIV_EN
        S_SFIX: begin
          // Truncating division: quotient sign from the operand signs, remainder follows the dividend.
          if (neg_q) q_reg <= ~q_reg + 1'b1;
          if (neg_r) r_reg <= ~r_reg + 1'b1;
          state <= S_DONE;
        end
`endif
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
          if (zero_div) begin
            quotient  <= '1;
            remainder <= q_reg;
            dbz       <= 1'b1;
          end else begin
            quotient  <= q_reg;
            remainder <= r_reg;
            dbz       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_12.sv
// Directed bench for seq_divider_12: vector table of divides plus hand-written multi-cycle sequences.
module tb_seq_divider_12;

  localparam int W = 12;
`ifdef SIGNED_DIV_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 13;
`endif

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         ready;
  logic         dbz;

  seq_divider_12 #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .ready     (ready),
    .dbz       (dbz)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: expected results queued at issue, popped at ready
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_z[$];
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  logic         prev_z = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_and_check(input string name);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    eq = exp_q.pop_front();
    er = exp_r.pop_front();
    ez = exp_z.pop_front();
    check({name, " quotient"}, 32'(quotient), 32'(eq));
    check({name, " remainder"}, 32'(remainder), 32'(er));
    check({name, " dbz"}, 32'(dbz), 32'(ez));
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
  endtask

  // driver: issue one divide at the next edge and wait (bounded) for its ready pulse
  task automatic run_div(input vec_t v, input string name);
    int cyc;
    int exp_lat;
    exp_lat = (v.b == '0) ? 1 : LAT;
    @(negedge clock);
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    exp_q.push_back(v.q);
    exp_r.push_back(v.r);
    exp_z.push_back(v.z);
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = W'($urandom_range(0, 4095));
    divisor  = W'($urandom_range(0, 4095));
    check({name, " busy after accept"}, 32'(busy), 32'd1);
    check({name, " ready low after accept"}, 32'(ready), 32'd0);
    check({name, " quotient held"}, 32'(quotient), 32'(prev_q));
    cyc = 0;
    while (!ready && cyc < 60) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    pop_and_check(name);
  endtask

  // a single 30-cycle observed divide with an extra start pulse poked at cycle poke
  task automatic poke_run(input vec_t v, input int poke, input string name);
    int pulses;
    int rdy_cyc;
    @(negedge clock);
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    exp_q.push_back(v.q);
    exp_r.push_back(v.r);
    exp_z.push_back(v.z);
    @(posedge clock);
    #1;
    start   = 1'b0;
    pulses  = 0;
    rdy_cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        pulses++;
        if (pulses == 1) begin
          rdy_cyc = i;
          pop_and_check(name);
        end
      end
      if (i == poke) begin
        start    = 1'b1;
        dividend = 12'd50;
        divisor  = 12'd5;
      end else begin
        start = 1'b0;
      end
    end
    check({name, " ready pulses"}, 32'(pulses), 32'd1);
    check({name, " latency"}, 32'(rdy_cyc), 32'(LAT));
    check({name, " idle at end"}, 32'(busy), 32'd0);
    check({name, " result kept"}, 32'(quotient), 32'(v.q));
  endtask

  vec_t vecs[$];

  initial begin
    int pulses;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

`ifdef SIGNED_DIV_EN
    vecs.push_back('{12'hF9C, 12'd7,   12'hFF2, 12'hFFE, 1'b0});
    vecs.push_back('{12'h800, 12'hFFF, 12'h800, 12'h000, 1'b0});
    vecs.push_back('{12'd100, 12'hFF9, 12'hFF2, 12'd2,   1'b0});
    vecs.push_back('{12'hF9C, 12'hFF9, 12'd14,  12'hFFE, 1'b0});
    vecs.push_back('{12'd5,   12'd0,   12'hFFF, 12'd5,   1'b1});
    vecs.push_back('{12'd7,   12'd2,   12'd3,   12'd1,   1'b0});
    vecs.push_back('{12'hFF9, 12'd0,   12'hFFF, 12'hFF9, 1'b1});
`else
    vecs.push_back('{12'd100,  12'd7,   12'd14,   12'd2,  1'b0});
    vecs.push_back('{12'd5,    12'd0,   12'hFFF,  12'd5,  1'b1});
    vecs.push_back('{12'hFFF,  12'h001, 12'hFFF,  12'd0,  1'b0});
    vecs.push_back('{12'h003,  12'hFFF, 12'd0,    12'd3,  1'b0});
    vecs.push_back('{12'hFFF,  12'hFFF, 12'd1,    12'd0,  1'b0});
    vecs.push_back('{12'd1000, 12'd10,  12'd100,  12'd0,  1'b0});
    vecs.push_back('{12'd2047, 12'd2,   12'd1023, 12'd1,  1'b0});
    vecs.push_back('{12'd0,    12'd5,   12'd0,    12'd0,  1'b0});
    vecs.push_back('{12'd12,   12'd13,  12'd0,    12'd12, 1'b0});
    vecs.push_back('{12'hABC,  12'h012, 12'd152,  12'd12, 1'b0});
    vecs.push_back('{12'hFFF,  12'd64,  12'd63,   12'd63, 1'b0});
`endif

    repeat (3) @(posedge clock);
    #1;
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // table vectors run back-to-back: each start lands in the ready cycle of the previous one
    foreach (vecs[i]) run_div(vecs[i], $sformatf("vec%0d", i));

    poke_run('{12'd100, 12'd7, 12'd14, 12'd2, 1'b0}, 5, "start mid-run");
    poke_run('{12'd1000, 12'd10, 12'd100, 12'd0, 1'b0}, LAT - 1, "start in DONE");

    // reset at cycle 6 of 100/7 aborts with no result
    @(negedge clock);
    dividend = 12'd100;
    divisor  = 12'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort dbz", 32'(dbz), 32'd0);
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (ready) pulses++;
    end
    check("abort no ready", 32'(pulses), 32'd0);
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    run_div('{12'd100, 12'd7, 12'd14, 12'd2, 1'b0}, "after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
